// File: rtl/wb_stream_port_pkg.sv
// Shared definitions for wb_stream_port.
//   DATA_W / SEL_W  : Wishbone data and byte-select widths.
//   TIMEOUT_RDATA   : value returned by a read that is forced by timeout.
//   state_t         : access FSM states.
//   mask_bytes()    : zeroes the bytes whose select bit is low.
package wb_stream_port_pkg;

  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;

  localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  function automatic logic [DATA_W-1:0] mask_bytes(input logic [DATA_W-1:0] d,
                                                  input logic [SEL_W-1:0]  sel);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < SEL_W; i++) begin
      m[8*i +: 8] = sel[i] ? d[8*i +: 8] : 8'h00;
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_stream_port_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, reset : clock and synchronous active-high reset (control only).
//   push, din  : write request and data; ignored while full.
//   pop, dout  : read request and head data; ignored while empty.
//   full, empty, level : occupancy status.
// Pointers wrap naturally (DEPTH is a power of two); the level is kept as a
// separate counter so full and empty are unambiguous.
module sync_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  // Gating uses the pre-edge level: no full bypass, no empty bypass.
  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/wb_stream_port.sv
// Single-word Wishbone classic slave bridging to two valid/ready streams.
//   aclk, reset            : clock, synchronous active-high reset.
//   wb_*                   : Wishbone slave; writes push TX, reads pop RX.
//                            err/rty/stall are tied low.
//   tx_valid_o/ready_i/data_o : TX stream out of the TX FIFO (FWFT head).
//   rx_valid_i/ready_o/data_i : RX stream into the RX FIFO.
//   tx_level_o, rx_level_o : FIFO occupancy.
//   timeout_o, timeout_clr_i : sticky forced-completion flag and its clear.
// An access that cannot proceed waits; after TIMEOUT cycles it is acked
// anyway (write dropped, read returns TIMEOUT_RDATA) because the upstream
// bridge only terminates on ack.
module wb_stream_port
  import wb_stream_port_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                   aclk,
  input  logic                   reset,
  input  logic                   wb_cyc_i,
  input  logic                   wb_stb_i,
  input  logic                   wb_we_i,
  input  logic [3:0]             wb_sel_i,
  input  logic [31:0]            wb_dat_i,
  output logic                   wb_ack_o,
  output logic                   wb_err_o,
  output logic                   wb_rty_o,
  output logic                   wb_stall_o,
  output logic [31:0]            wb_dat_o,
  output logic                   tx_valid_o,
  input  logic                   tx_ready_i,
  output logic [31:0]            tx_data_o,
  input  logic                   rx_valid_i,
  output logic                   rx_ready_o,
  input  logic [31:0]            rx_data_i,
  output logic [$clog2(DEPTH):0] tx_level_o,
  output logic [$clog2(DEPTH):0] rx_level_o,
  output logic                   timeout_o,
  input  logic                   timeout_clr_i
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  wait_cnt;
  logic              req;
  logic              avail;
  logic              serving;
  logic              do_action;
  logic              forced;
  logic              tx_push;
  logic              rx_pop;
  logic              tx_full;
  logic              tx_empty;
  logic              rx_full;
  logic              rx_empty;
  logic [DATA_W-1:0] rx_head;

  assign wb_err_o   = 1'b0;
  assign wb_rty_o   = 1'b0;
  assign wb_stall_o = 1'b0;

  assign req     = wb_cyc_i & wb_stb_i;
  assign avail   = wb_we_i ? ~tx_full : ~rx_empty;
  assign serving = (state == IDLE) || (state == WAIT);

  // ACK never samples req, so a strobe still high there is not re-served.
  assign do_action = serving & req & avail;
  assign forced    = (state == WAIT) & req & ~avail & (wait_cnt == CNT_LAST);
  assign tx_push   = do_action & wb_we_i;
  assign rx_pop    = do_action & ~wb_we_i;

  assign wb_ack_o   = (state == ACK);
  assign tx_valid_o = ~tx_empty;
  assign rx_ready_o = ~rx_full;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req) state_nxt = avail ? ACK : WAIT;
      WAIT: begin
        if (!req)                state_nxt = IDLE;
        else if (avail || forced) state_nxt = ACK;
        else                      state_nxt = WAIT;
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      wb_dat_o  <= '0;
      timeout_o <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == IDLE) begin
        wait_cnt <= '0;
      end else if (state == WAIT && state_nxt == WAIT) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end

      if (rx_pop) begin
        wb_dat_o <= rx_head;
      end else if (forced && !wb_we_i) begin
        wb_dat_o <= TIMEOUT_RDATA;
      end

      // A new timeout wins over a simultaneous clear.
      if (forced) begin
        timeout_o <= 1'b1;
      end else if (timeout_clr_i) begin
        timeout_o <= 1'b0;
      end
    end
  end

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_tx_fifo (
    .clk   (aclk),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_valid_o & tx_ready_i),
    .din   (mask_bytes(wb_dat_i, wb_sel_i)),
    .dout  (tx_data_o),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level_o)
  );

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_rx_fifo (
    .clk   (aclk),
    .reset (reset),
    .push  (rx_valid_i & rx_ready_o),
    .pop   (rx_pop),
    .din   (rx_data_i),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level_o)
  );

endmodule
